gpio_uart_tx: RTL and testbench

- Downstream consumer of the GPIO output register in the MIPS memory-mapped I/O path.
- Accepts a byte plus a one-cycle load strobe, generated by the same address decode and store enable that update the GPIO register.
- Buffers each byte in a small FIFO and serialises it as 8N1 UART frames on a single registered pin.
- Lets software stream bytes to a host terminal by issuing repeated stores to the GPIO address.

---
 rtl/gpio_uart_tx.sv | 184 ++++++++++++++++++
 tb/tb_gpio_uart_tx.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/gpio_uart_tx.sv
// Byte FIFO plus 8N1 UART serialiser fed by GPIO store strobes.
// Optional even-parity bit between data and stop: define GPIO_UART_TX_PARITY_EN.
module gpio_uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_DIV   = 434,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          load,
  output logic                          tx,
  output logic                          busy,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(BAUD_DIV);
  localparam int IW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef GPIO_UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                state_q, state_d;
  logic [BW-1:0]         baud_cnt_q, baud_cnt_d;
  logic [IW-1:0]         bit_idx_q, bit_idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  overflow_q, overflow_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
`ifdef GPIO_UART_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  logic baud_end, full_w, empty_w, pop, push;

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    overflow_d = overflow_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    mem_d      = mem_q;
`ifdef GPIO_UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    baud_end = (baud_cnt_q == BAUD_LAST);
    full_w   = (count_q == FULL_CNT);
    empty_w  = (count_q == '0);
    // A pop frees a slot on the same edge, so a load into a full FIFO is kept then
    pop      = !empty_w && ((state_q == IDLE) || (state_q == STOP && baud_end));
    push     = load && (!full_w || pop);

    if (load && !push) overflow_d = 1'b1;
    if (push) begin
      mem_d[wr_ptr_q] = data_in;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    baud_cnt_d = baud_end ? '0 : baud_cnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        tx_d       = 1'b1;
        baud_cnt_d = '0;
      end
      START: if (baud_end) begin
        state_d   = DATA;
        bit_idx_d = '0;
        tx_d      = shift_q[0];
      end
      DATA: if (baud_end) begin
        if (bit_idx_q == LAST_BIT) begin
`ifdef GPIO_UART_TX_PARITY_EN
          state_d = PARITY;
          tx_d    = parity_q;
`else
          state_d = STOP;
          tx_d    = 1'b1;
`endif
        end else begin
          shift_d   = shift_q >> 1;
          tx_d      = shift_d[0];
          bit_idx_d = bit_idx_q + 1'b1;
        end
      end
`ifdef GPIO_UART_TX_PARITY_EN
      PARITY: if (baud_end) begin
        state_d = STOP;
        tx_d    = 1'b1;
      end
`endif
      STOP: if (baud_end) begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Popping overrides the STOP->IDLE exit, giving gapless back-to-back frames
    if (pop) begin
      shift_d    = mem_q[rd_ptr_q];
      state_d    = START;
      baud_cnt_d = '0;
      bit_idx_d  = '0;
      tx_d       = 1'b0;
`ifdef GPIO_UART_TX_PARITY_EN
      parity_d   = ^mem_q[rd_ptr_q];
`endif
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
`ifdef GPIO_UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      mem_q      <= mem_d;
`ifdef GPIO_UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_gpio_uart_tx.sv
// Randomized bench for gpio_uart_tx, checked every cycle against a frame-level
// model (byte queue plus precomputed frame bit vector).
module tb_gpio_uart_tx;
  localparam int DW    = 8;
  localparam int BAUD  = 4;
  localparam int DEPTH = 4;
`ifdef GPIO_UART_TX_PARITY_EN
  localparam int NBITS = DW + 3;
`else
  localparam int NBITS = DW + 2;
`endif
  localparam int FL = NBITS * BAUD;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          load = 1'b0;
  logic          tx, busy, fifo_full, fifo_empty, overflow;
  logic [2:0]    fifo_count;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0]    mq[$];
  bit               mActive;
  int               mT;
  logic [NBITS-1:0] mFrame;
  bit               mOvf;

  gpio_uart_tx #(.DATA_WIDTH(DW), .BAUD_DIV(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .load(load), .tx(tx),
    .busy(busy), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [NBITS-1:0] buildFrame(input logic [DW-1:0] b);
    logic [NBITS-1:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < DW; i++) f[1+i] = b[i];
`ifdef GPIO_UART_TX_PARITY_EN
    f[DW+1] = ^b;
`endif
    return f;
  endfunction

  task automatic modelReset();
    mq.delete();
    mActive = 0;
    mT = 0;
    mOvf = 0;
  endtask

  // Frame-level view: a frame lasts FL cycles; the next queued byte starts on its last edge
  task automatic modelStep(input logic ld, input logic [DW-1:0] d);
    bit frameEnd, doPop, wasFull;
    frameEnd = mActive && (mT == FL - 1);
    doPop    = (mq.size() > 0) && (!mActive || frameEnd);
    wasFull  = (mq.size() == DEPTH);
    if (mActive) begin
      mT++;
      if (frameEnd) mActive = 0;
    end
    if (doPop) begin
      mFrame  = buildFrame(mq.pop_front());
      mActive = 1;
      mT      = 0;
    end
    if (ld) begin
      if (!wasFull || doPop) mq.push_back(d);
      else mOvf = 1;
    end
  endtask

  task automatic checkAll();
    logic expTx;
    expTx = mActive ? mFrame[mT / BAUD] : 1'b1;
    checkOutput("tx", tx, expTx);
    checkOutput("busy", busy, mActive);
    checkOutput("fifo_count", fifo_count, mq.size());
    checkOutput("fifo_full", fifo_full, mq.size() == DEPTH);
    checkOutput("fifo_empty", fifo_empty, mq.size() == 0);
    checkOutput("overflow", overflow, mOvf);
  endtask

  task automatic applyStimulus(input logic ld, input logic [DW-1:0] d);
    load = ld;
    data_in = d;
    @(posedge clk);
    modelStep(ld, d);
    #1;
    checkAll();
    load = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b0;
    modelReset();
    #1;
    checkOutput("rst_tx", tx, 1'b1);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_count", fifo_count, 0);
    checkOutput("rst_empty", fifo_empty, 1'b1);
    checkOutput("rst_full", fifo_full, 1'b0);
    checkOutput("rst_ovf", overflow, 1'b0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    bit found;
    int pct;
    modelReset();
    mFrame = '1;
    #12;
    doReset();

    // Single byte: full frame then idle
    applyStimulus(1'b1, DW'($urandom));
    repeat (FL + 10) applyStimulus(1'b0, '0);

    // Three consecutive loads: back-to-back frames
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, DW'($urandom));
    repeat (3 * FL + 10) applyStimulus(1'b0, '0);

    // Six consecutive loads: one popped, four stored, one dropped
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, DW'($urandom));
    checkOutput("six_ovf", overflow, 1'b1);
    checkOutput("six_full", fifo_full, 1'b1);
    repeat (5 * FL + 10) applyStimulus(1'b0, '0);
    checkOutput("ovf_sticky", overflow, 1'b1);

    // Full FIFO with a load on the stop-bit-end pop edge
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, DW'($urandom));
    found = 0;
    for (int i = 0; i < 3 * FL && !found; i++) begin
      if (mActive && mT == FL - 1 && mq.size() == DEPTH) found = 1;
      else applyStimulus(1'b0, '0);
    end
    checkOutput("wait_stop_end", found, 1'b1);
    applyStimulus(1'b1, DW'($urandom));
    checkOutput("pop_load_count", fifo_count, DEPTH);
    checkOutput("pop_load_ovf", overflow, 1'b0);
    repeat (5 * FL + 10) applyStimulus(1'b0, '0);

    // Asynchronous reset in the middle of a frame
    applyStimulus(1'b1, DW'($urandom));
    applyStimulus(1'b1, DW'($urandom));
    repeat (15) applyStimulus(1'b0, '0);
    #2;
    reset = 1'b0;
    modelReset();
    #1;
    checkOutput("async_tx", tx, 1'b1);
    checkOutput("async_busy", busy, 1'b0);
    checkOutput("async_count", fifo_count, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (FL + 5) applyStimulus(1'b0, '0);

    // Random traffic at several load densities
    for (int seg = 0; seg < 3; seg++) begin
      pct = (seg == 0) ? 5 : (seg == 1) ? 30 : 80;
      repeat (600) applyStimulus($urandom_range(0, 99) < pct, DW'($urandom));
    end
    repeat (6 * FL) applyStimulus(1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
